// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - elaboration-time helpers for the serial pattern detector
package seq_det_pkg;

  localparam int MAX_PAT_LEN = 16;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < n) r = i + 1;
    end
    return r;
  endfunction

  // Longest prefix of pattern that is a suffix of (first `state` pattern bits, then b),
  // capped at len-1 so a completed match falls back to its longest proper border.
  function automatic int kmp_next(input logic [MAX_PAT_LEN-1:0] pattern, input int len,
                                  input int state, input logic b);
    int   res;
    int   k;
    logic ok;
    logic sb;
    res = 0;
    for (int l = MAX_PAT_LEN - 1; l >= 1; l--) begin
      if (res == 0 && l <= state + 1 && l <= len - 1) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_PAT_LEN; j++) begin
          if (j < l) begin
            k  = state + 1 - l + j;
            sb = (k == state) ? b : pattern[4'(len - 1 - k)];
            if (sb != pattern[4'(len - 1 - j)]) ok = 1'b0;
          end
        end
        if (ok) res = l;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det.sv
// rtl/seq_det.sv - Moore-style serial pattern detector with KMP fallback
module seq_det
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0101,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic din,
  input  logic reset,
  input  logic clk,
  output logic z
);

  localparam int SW = clog2(PAT_LEN);
  localparam logic [MAX_PAT_LEN-1:0] PAT_EXT = MAX_PAT_LEN'(PATTERN);

  logic [SW-1:0] r_s;
  logic [SW-1:0] w_next;
  logic          w_exp;
  logic          w_done;

  // Inputs to kmp_next other than r_s/din are constants, so this folds to a per-state table.
  always_comb begin
    w_exp  = PAT_EXT[4'(PAT_LEN - 1 - int'(r_s))];
    w_done = (din == w_exp) && (r_s == SW'(PAT_LEN - 1));
    w_next = SW'(kmp_next(PAT_EXT, PAT_LEN, int'(r_s), din));
    if (w_done && !OVERLAP) w_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s <= '0;
      z   <= 1'b0;
    end else begin
      r_s <= w_next;
      z   <= w_done;
    end
  end

endmodule

// File: tb/tb_seq_det.sv
// tb/tb_seq_det.sv - directed self-checking bench for seq_det
module tb_seq_det;

  logic clk = 1'b0;
  logic din_a, rst_a, din_b, rst_b, din_c, rst_c;
  logic z_a, z_b, z_c;
  int   checks = 0;
  int   failures = 0;

  seq_det dut_a (.din(din_a), .reset(rst_a), .clk(clk), .z(z_a));
  seq_det #(.OVERLAP(1'b0)) dut_b (.din(din_b), .reset(rst_b), .clk(clk), .z(z_b));
  seq_det #(.PAT_LEN(3), .PATTERN(3'b110)) dut_c (.din(din_c), .reset(rst_c), .clk(clk), .z(z_c));

  always #5 clk = ~clk;

  task automatic step(input int u, input logic d, input logic r, input logic exp, input string tag);
    logic obs;
    case (u)
      0:       begin din_a = d; rst_a = r; end
      1:       begin din_b = d; rst_b = r; end
      default: begin din_c = d; rst_c = r; end
    endcase
    @(posedge clk);
    #1;
    obs = (u == 0) ? z_a : (u == 1) ? z_b : z_c;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed z=%0b expected z=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input logic [1:0] exp, input string tag);
    checks++;
    assert (dut_a.r_s === exp) else begin
      failures++;
      $error("FAIL %s: observed s=%0d expected s=%0d", tag, dut_a.r_s, exp);
    end
  endtask

  task automatic run_stream(input int u, input logic [31:0] bits, input logic [31:0] zexp,
                            input int n, input string tag);
    logic [31:0] b;
    logic [31:0] e;
    b = bits;
    e = zexp;
    for (int i = 0; i < n; i++)
      step(u, b[n-1-i], 1'b1, e[n-1-i], $sformatf("%s[%0d]", tag, i + 1));
  endtask

  initial begin
    din_a = 0; rst_a = 0; din_b = 0; rst_b = 0; din_c = 0; rst_c = 0;

    for (int i = 0; i < 5; i++) begin
      step(0, logic'(i[0]), 1'b0, 1'b0, "reset_hold_z");
      chk_s(2'd0, "reset_hold_s");
    end

    run_stream(0, 32'b01111101010111111010101, 32'b00000000010100000000101, 23, "ovl");

    step(1, 1'b0, 1'b0, 1'b0, "nov_reset");
    run_stream(1, 32'b01111101010111111010101, 32'b00000000010000000000100, 23, "nov");

    step(0, 1'b0, 1'b0, 1'b0, "mid_pre_reset");
    run_stream(0, 32'b010, 32'b000, 3, "mid_a");
    step(0, 1'b1, 1'b0, 1'b0, "mid_reset_edge");
    chk_s(2'd0, "mid_reset_s");
    step(0, 1'b1, 1'b1, 1'b0, "mid_after");
    run_stream(0, 32'b0101, 32'b0001, 4, "mid_b");

    step(0, 1'b0, 1'b0, 1'b0, "sup_pre_reset");
    run_stream(0, 32'b010, 32'b000, 3, "sup");
    step(0, 1'b1, 1'b0, 1'b0, "sup_reset_kills_z");

    step(0, 1'b0, 1'b0, 1'b0, "fb_pre_reset");
    step(0, 1'b0, 1'b1, 1'b0, "fb[1]");
    chk_s(2'd1, "fb_s1");
    step(0, 1'b1, 1'b1, 1'b0, "fb[2]");
    chk_s(2'd2, "fb_s2");
    step(0, 1'b1, 1'b1, 1'b0, "fb[3]");
    chk_s(2'd0, "fb_s2_to_s0");
    run_stream(0, 32'b0101, 32'b0001, 4, "fb_tail");
    chk_s(2'd2, "fb_overlap_s");

    step(2, 1'b0, 1'b0, 1'b0, "p110_reset");
    run_stream(2, 32'b1110110, 32'b0001001, 7, "p110");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_det.md
# seq_det

Serial pattern detector that samples a 1-bit input stream on each rising clock edge and raises a registered one-cycle flag whenever the most recent bits equal a configured pattern (default `0101`, MSB first in time). It sits at the edge of a serial datapath as a framing/marker detector. It is a single-clock Moore-style FSM with a selectable overlapping or non-overlapping match mode.

## Interface
Parameters:
- `PAT_LEN`, default 4: pattern length in bits, legal range 2..16.
- `PATTERN`, default `4'b0101`: pattern bits. Bit `PAT_LEN-1` is the first bit received; bit 0 is the last.
- `OVERLAP`, default 1: 1 allows overlapping matches; 0 restarts the search after each match.

Ports (positional order is `din, reset, clk, z`):
- `clk` input, 1 bit: single clock; everything samples on its rising edge.
- `reset` input, 1 bit: reset is synchronous and active-low (`reset==0` at a rising `clk` edge resets the block).
- `din` input, 1 bit: serial data, sampled on every rising edge.
- `z` output, 1 bit: registered match flag.

## Operation
- State `s` counts matched prefix bits, 0..`PAT_LEN-1`. `s` is encoded in `$clog2(PAT_LEN)` bits.
- Each edge tests `din` against the expected bit `PATTERN[PAT_LEN-1-s]`.
- If `din` matches and `s < PAT_LEN-1`: `s <= s+1`, `z <= 0`.
- If `din` matches and `s == PAT_LEN-1` (completion):
  - `z <= 1`.
  - With `OVERLAP=1`: `s <=` length of the longest proper prefix of `PATTERN` that is also a suffix of it. For `0101` this is 2.
  - With `OVERLAP=0`: `s <= 0`.
- If `din` mismatches:
  - `s <=` length of the longest prefix of `PATTERN` that is a suffix of (the matched prefix followed by `din`). This is the KMP fallback.
  - `z <= 0`.
- The fallback and overlap tables are computed at elaboration from `PATTERN`. No run-time table storage.
- Fixed `0101` transitions with `OVERLAP=1`, in the form state: on 0 / on 1:
  - S0: S1 / S0
  - S1: S1 / S2
  - S2: S3 / S0
  - S3: S1 / S2, and z=1 when `din` is 1.
- `z` is never asserted for two consecutive cycles with the default pattern. A pattern such as `11` with `OVERLAP=1` can assert `z` on consecutive cycles.

## Timing
- Latency: `z` goes high in the clock cycle immediately after the edge that samples the final pattern bit. It stays high for exactly one cycle per match.
- Reset: `reset==0` at an edge forces `s <= 0` and `z <= 0`. Reset has priority over `din`.
- `din` sampled during a reset edge is discarded. Matching restarts with the first edge after `reset` returns to 1.
- Reset asserted mid-pattern discards the partial match. No match may span a reset.
- Reset asserted in the cycle where `z` would rise suppresses that `z`.
- At power-up, `z` is undefined until the first reset edge. The bench must apply reset.

## Structure
- Package `seq_det_pkg` holds:
  - the state-width function `clog2`;
  - the elaboration-time function `kmp_next(pattern, len, state, bit)` that returns the next state.
- The module body is one `always` block on `posedge clk` for state and `z`, plus combinational next-state logic that calls `kmp_next`.
- No sub-module is needed. The FSM stays in one module.

## Test plan
- Reset hold: hold `reset=0` for 5 edges while `din` toggles. Required: `z=0` and `s=0` throughout.
- Default overlap stream: release reset, then drive `din` on successive edges: 0,1,1,1,1,1,0,1,0,1,0,1,1,1,1,1,1,0,1,0,1,0,1. Required: `z` high for one cycle after the 10th, 12th, 21st and 23rd samples, and low elsewhere.
- Non-overlap: same stream with `OVERLAP=0`. Required: `z` high only after the 10th and 21st samples.
- Mid-pattern reset: drive 0,1,0, then one edge with `reset=0`, then 1. Required: no `z`. Then drive 0,1,0,1. Required: `z` after the 4th bit.
- Fallback check: drive 0,1,1,0,1,0,1. Required: a single `z` after the final bit; the state drops S2→S0 on the `1` at the third sample.
- Parameter sweep: `PATTERN=3'b110`, `PAT_LEN=3`, stream 1,1,1,0,1,1,0. Required: `z` after the 4th and 7th samples.
